// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants, control bit indices and bundle types
package mips_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    // EX control bundle bit positions {RegDst, ALUOp, ALUSrc}
    localparam int EX_REGDST   = 2;
    localparam int EX_ALUOP    = 1;
    localparam int EX_ALUSRC   = 0;

    // M control bundle bit positions {Branch, MemRead, MemWrite}
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;

    // WB control bundle bit positions {RegWrite, MemtoReg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    typedef struct packed {
        logic [2:0] ex;
        logic [2:0] m;
        logic [1:0] wb;
    } ctrl_t;

    // A bubble carries no side effects: every control bit low.
    function automatic ctrl_t bubble_ctrl();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use dependency check between EX and ID
module load_use_detect #(
    parameter int RW = mips_pkg::RW
) (
    input  logic          ex_valid,
    input  logic          ex_mem_read,
    input  logic [RW-1:0] ex_rt,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    output logic          hazard
);

    logic rt_nonzero;
    logic rt_match;

    // A load in EX writes ex_rt; $zero is never a real dependency.
    always_comb begin
        rt_nonzero = (ex_rt != '0);
        rt_match   = (ex_rt == id_rs) || (ex_rt == id_rt);
        hazard     = ex_valid && ex_mem_read && rt_nonzero && id_valid && rt_match;
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion; optional ID_EX_PERF_CNT_EN bubble counter
module id_ex_stage #(
    parameter int DW = mips_pkg::DW,
    parameter int RW = mips_pkg::RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [2:0]    id_ex_ctrl,
    input  logic [2:0]    id_m_ctrl,
    input  logic [1:0]    id_wb_ctrl,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_pc4,
    input  logic          flush,
    output logic          ex_valid,
    output logic [2:0]    ex_ex_ctrl,
    output logic [2:0]    ex_m_ctrl,
    output logic [1:0]    ex_wb_ctrl,
    output logic [DW-1:0] ex_rd1,
    output logic [DW-1:0] ex_rd2,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc4,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] ex_rd,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]   bubble_cnt,
`endif
    output logic          hazard_stall
);

    import mips_pkg::*;

    logic          hazard;
    logic          bubble;
    ctrl_t         ctrl_in;

    logic          ex_valid_d,   ex_valid_q;
    ctrl_t         ex_ctrl_d,    ex_ctrl_q;
    logic [DW-1:0] ex_rd1_d,     ex_rd1_q;
    logic [DW-1:0] ex_rd2_d,     ex_rd2_q;
    logic [DW-1:0] ex_imm_d,     ex_imm_q;
    logic [DW-1:0] ex_pc4_d,     ex_pc4_q;
    logic [RW-1:0] ex_rs_d,      ex_rs_q;
    logic [RW-1:0] ex_rt_d,      ex_rt_q;
    logic [RW-1:0] ex_rd_d,      ex_rd_q;

    load_use_detect #(
        .RW (RW)
    ) u_load_use_detect (
        .ex_valid    (ex_valid_q),
        .ex_mem_read (ex_ctrl_q.m[M_MEMREAD]),
        .ex_rt       (ex_rt_q),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .hazard      (hazard)
    );

    // Flush overrides the stall: the squashed ID instruction must not be held.
    always_comb begin
        hazard_stall = hazard && !flush;
        bubble       = flush || hazard;
    end

    // Bubble mux: flush and hazard both load an all-zero slot, otherwise capture ID.
    always_comb begin
        ctrl_in.ex = id_ex_ctrl;
        ctrl_in.m  = id_m_ctrl;
        ctrl_in.wb = id_wb_ctrl;

        ex_valid_d = id_valid;
        ex_ctrl_d  = id_valid ? ctrl_in : bubble_ctrl();
        ex_rd1_d   = id_rd1;
        ex_rd2_d   = id_rd2;
        ex_imm_d   = id_imm;
        ex_pc4_d   = id_pc4;
        ex_rs_d    = id_rs;
        ex_rt_d    = id_rt;
        ex_rd_d    = id_rd;

        if (bubble) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = bubble_ctrl();
            ex_rd1_d   = '0;
            ex_rd2_d   = '0;
            ex_imm_d   = '0;
            ex_pc4_d   = '0;
            ex_rs_d    = '0;
            ex_rt_d    = '0;
            ex_rd_d    = '0;
        end
    end

    // ID/EX register loads every cycle; reset yields an empty EX slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_rd1_q   <= '0;
            ex_rd2_q   <= '0;
            ex_imm_q   <= '0;
            ex_pc4_q   <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rd1_q   <= ex_rd1_d;
            ex_rd2_q   <= ex_rd2_d;
            ex_imm_q   <= ex_imm_d;
            ex_pc4_q   <= ex_pc4_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_rd_q    <= ex_rd_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_ex_ctrl = ex_ctrl_q.ex;
    assign ex_m_ctrl  = ex_ctrl_q.m;
    assign ex_wb_ctrl = ex_ctrl_q.wb;
    assign ex_rd1     = ex_rd1_q;
    assign ex_rd2     = ex_rd2_q;
    assign ex_imm     = ex_imm_q;
    assign ex_pc4     = ex_pc4_q;
    assign ex_rs      = ex_rs_q;
    assign ex_rt      = ex_rt_q;
    assign ex_rd      = ex_rd_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_d, bubble_cnt_q;

    // Count only hazard-inserted bubbles; flushes are excluded, value saturates.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (hazard_stall && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    // Counter register, cleared with the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - vector table, load-use sequences and randomized model check for id_ex_stage
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_ex_ctrl;
    logic [2:0]  id_m_ctrl;
    logic [1:0]  id_wb_ctrl;
    logic [31:0] id_rd1, id_rd2, id_imm, id_pc4;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        flush;
    logic        ex_valid;
    logic [2:0]  ex_ex_ctrl, ex_m_ctrl;
    logic [1:0]  ex_wb_ctrl;
    logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        hazard_stall;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    id_ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_ex_ctrl   (id_ex_ctrl),
        .id_m_ctrl    (id_m_ctrl),
        .id_wb_ctrl   (id_wb_ctrl),
        .id_rd1       (id_rd1),
        .id_rd2       (id_rd2),
        .id_imm       (id_imm),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_pc4       (id_pc4),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_ex_ctrl   (ex_ex_ctrl),
        .ex_m_ctrl    (ex_m_ctrl),
        .ex_wb_ctrl   (ex_wb_ctrl),
        .ex_rd1       (ex_rd1),
        .ex_rd2       (ex_rd2),
        .ex_imm       (ex_imm),
        .ex_pc4       (ex_pc4),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_rd        (ex_rd),
`ifdef ID_EX_PERF_CNT_EN
        .bubble_cnt   (bubble_cnt),
`endif
        .hazard_stall (hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [2:0]  ex;
        logic [2:0]  m;
        logic [1:0]  wb;
        logic [31:0] rd1, rd2, imm, pc4;
        logic [4:0]  rs, rt, rd;
    } st_t;

    typedef struct {
        logic        rst, flush, idv;
        logic [2:0]  ex, m;
        logic [1:0]  wb;
        logic [31:0] rd1;
        logic [4:0]  rs, rt, rd;
        logic        e_stall, e_valid;
        logic [2:0]  e_ex, e_m;
        logic [1:0]  e_wb;
        logic [31:0] e_rd1;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    st_t         mdl;
    logic [31:0] mdl_cnt;
    logic        prev_stall;
    logic        last_stall;
    vec_t        vecs[$];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic f, input logic v, input logic [2:0] ex,
                          input logic [2:0] m, input logic [1:0] wb, input logic [31:0] d1,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        rst = r; flush = f; id_valid = v;
        id_ex_ctrl = ex; id_m_ctrl = m; id_wb_ctrl = wb;
        id_rd1 = d1; id_rd2 = d1 ^ 32'hA5A5_0000; id_imm = ~d1; id_pc4 = d1 + 32'd4;
        id_rs = rs; id_rt = rt; id_rd = rd;
    endtask

    // One clock: check the combinational stall mid-cycle, then the registered state.
    task automatic cycle();
        logic dep, es;
        st_t  nx, got;
        @(negedge clk);
        dep = mdl.v && mdl.m[1] && (mdl.rt != 5'd0) && id_valid &&
              ((mdl.rt == id_rs) || (mdl.rt == id_rt));
        es  = dep && !flush;
        chk("hazard_stall", {159'd0, hazard_stall}, {159'd0, es});
        chk("one_cycle_stall", {159'd0, prev_stall & hazard_stall}, 160'd0);
        prev_stall = hazard_stall;
        last_stall = hazard_stall;
        nx = '0;
        if (rst) begin
            mdl_cnt = 32'd0;
        end else if (flush || dep) begin
            if (es && mdl_cnt != 32'hFFFF_FFFF) mdl_cnt = mdl_cnt + 32'd1;
        end else begin
            nx.v   = id_valid;
            nx.ex  = id_valid ? id_ex_ctrl : 3'd0;
            nx.m   = id_valid ? id_m_ctrl  : 3'd0;
            nx.wb  = id_valid ? id_wb_ctrl : 2'd0;
            nx.rd1 = id_rd1; nx.rd2 = id_rd2; nx.imm = id_imm; nx.pc4 = id_pc4;
            nx.rs  = id_rs;  nx.rt  = id_rt;  nx.rd  = id_rd;
        end
        @(posedge clk);
        #1;
        mdl = nx;
        got = {ex_valid, ex_ex_ctrl, ex_m_ctrl, ex_wb_ctrl, ex_rd1, ex_rd2, ex_imm, ex_pc4,
               ex_rs, ex_rt, ex_rd};
        chk("ex_state", {8'd0, got}, {8'd0, mdl});
`ifdef ID_EX_PERF_CNT_EN
        chk("bubble_cnt", {128'd0, bubble_cnt}, {128'd0, mdl_cnt});
`endif
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic v, input logic [2:0] ex,
                                input logic [2:0] m, input logic [1:0] wb, input logic [31:0] d1,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic es, input logic ev, input logic [2:0] eex,
                                input logic [2:0] em, input logic [1:0] ewb, input logic [31:0] ed1);
        vec_t t;
        t.rst = r; t.flush = f; t.idv = v; t.ex = ex; t.m = m; t.wb = wb; t.rd1 = d1;
        t.rs = rs; t.rt = rt; t.rd = rd;
        t.e_stall = es; t.e_valid = ev; t.e_ex = eex; t.e_m = em; t.e_wb = ewb; t.e_rd1 = ed1;
        return t;
    endfunction

    initial begin
        mdl = '0; mdl_cnt = 32'd0; prev_stall = 1'b0; last_stall = 1'b0;
        set_in(1'b1, 1'b0, 1'b1, 3'b110, 3'b010, 2'b11, 32'h1111, 5'd8, 5'd8, 5'd3);
        @(posedge clk);
        #1;

        //            rst  fl   idv  ex      m       wb     rd1       rs  rt  rd   stall valid e_ex    e_m     e_wb   e_rd1
        vecs.push_back(mk(1, 0, 1, 3'b110, 3'b010, 2'b11, 32'h1234, 8,  8,  3,  0, 0, 3'b000, 3'b000, 2'b00, 32'h0));
        vecs.push_back(mk(1, 0, 1, 3'b001, 3'b010, 2'b11, 32'h0009, 4,  4,  4,  0, 0, 3'b000, 3'b000, 2'b00, 32'h0));
        vecs.push_back(mk(0, 0, 1, 3'b110, 3'b000, 2'b10, 32'h0005, 1,  2,  3,  0, 1, 3'b110, 3'b000, 2'b10, 32'h5));
        vecs.push_back(mk(0, 0, 1, 3'b001, 3'b010, 2'b11, 32'h0100, 1,  8,  0,  0, 1, 3'b001, 3'b010, 2'b11, 32'h100));
        vecs.push_back(mk(0, 0, 1, 3'b110, 3'b000, 2'b10, 32'h0020, 8,  9,  10, 1, 0, 3'b000, 3'b000, 2'b00, 32'h0));
        vecs.push_back(mk(0, 0, 1, 3'b110, 3'b000, 2'b10, 32'h0020, 8,  9,  10, 0, 1, 3'b110, 3'b000, 2'b10, 32'h20));
        vecs.push_back(mk(0, 0, 1, 3'b001, 3'b010, 2'b11, 32'h0030, 1,  0,  0,  0, 1, 3'b001, 3'b010, 2'b11, 32'h30));
        vecs.push_back(mk(0, 0, 1, 3'b110, 3'b000, 2'b10, 32'h0040, 0,  0,  5,  0, 1, 3'b110, 3'b000, 2'b10, 32'h40));
        vecs.push_back(mk(0, 0, 1, 3'b001, 3'b010, 2'b11, 32'h0050, 2,  8,  0,  0, 1, 3'b001, 3'b010, 2'b11, 32'h50));
        vecs.push_back(mk(0, 1, 1, 3'b110, 3'b000, 2'b10, 32'h0060, 8,  9,  10, 0, 0, 3'b000, 3'b000, 2'b00, 32'h0));
        vecs.push_back(mk(0, 0, 0, 3'b110, 3'b010, 2'b11, 32'h0070, 1,  2,  3,  0, 0, 3'b000, 3'b000, 2'b00, 32'h70));
        vecs.push_back(mk(0, 0, 1, 3'b001, 3'b010, 2'b11, 32'h0080, 1,  4,  0,  0, 1, 3'b001, 3'b010, 2'b11, 32'h80));
        vecs.push_back(mk(1, 0, 1, 3'b110, 3'b000, 2'b10, 32'h0090, 4,  2,  3,  1, 0, 3'b000, 3'b000, 2'b00, 32'h0));
        vecs.push_back(mk(0, 0, 1, 3'b110, 3'b000, 2'b10, 32'h0090, 4,  2,  3,  0, 1, 3'b110, 3'b000, 2'b10, 32'h90));
        vecs.push_back(mk(0, 0, 1, 3'b001, 3'b010, 2'b11, 32'h00A0, 1,  5,  0,  0, 1, 3'b001, 3'b010, 2'b11, 32'hA0));
        vecs.push_back(mk(0, 0, 1, 3'b001, 3'b001, 2'b00, 32'h00B0, 1,  5,  0,  1, 0, 3'b000, 3'b000, 2'b00, 32'h0));
        vecs.push_back(mk(0, 0, 1, 3'b001, 3'b001, 2'b00, 32'h00B0, 1,  5,  0,  0, 1, 3'b001, 3'b001, 2'b00, 32'hB0));
        vecs.push_back(mk(0, 0, 1, 3'b001, 3'b010, 2'b11, 32'h00C0, 1,  6,  0,  0, 1, 3'b001, 3'b010, 2'b11, 32'hC0));
        vecs.push_back(mk(0, 0, 0, 3'b110, 3'b000, 2'b10, 32'h00D0, 6,  6,  7,  0, 0, 3'b000, 3'b000, 2'b00, 32'hD0));

        foreach (vecs[i]) begin
            set_in(vecs[i].rst, vecs[i].flush, vecs[i].idv, vecs[i].ex, vecs[i].m, vecs[i].wb,
                   vecs[i].rd1, vecs[i].rs, vecs[i].rt, vecs[i].rd);
            cycle();
            chk($sformatf("vec%0d_stall", i), {159'd0, last_stall}, {159'd0, vecs[i].e_stall});
            chk($sformatf("vec%0d_out", i),
                {118'd0, ex_valid, ex_ex_ctrl, ex_m_ctrl, ex_wb_ctrl, ex_rd1},
                {118'd0, vecs[i].e_valid, vecs[i].e_ex, vecs[i].e_m, vecs[i].e_wb, vecs[i].e_rd1});
        end

        // Three load-use stalls from a clean reset, then reset clears the count.
        set_in(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 2'b00, 32'h0, 5'd0, 5'd0, 5'd0);
        cycle();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 1'b0, 1'b1, 3'b001, 3'b010, 2'b11, 32'h200 + k, 5'd1, 5'd8, 5'd0);
            cycle();
            set_in(1'b0, 1'b0, 1'b1, 3'b110, 3'b000, 2'b10, 32'h300 + k, 5'd8, 5'd2, 5'd9);
            cycle();
            chk("seq_stall", {159'd0, last_stall}, {159'd0, 1'b1});
            cycle();
            chk("seq_add_enters", {159'd0, last_stall}, 160'd0);
        end
`ifdef ID_EX_PERF_CNT_EN
        chk("perf_cnt_3", {128'd0, bubble_cnt}, {128'd0, 32'd3});
`endif
        set_in(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 2'b00, 32'h0, 5'd0, 5'd0, 5'd0);
        cycle();
`ifdef ID_EX_PERF_CNT_EN
        chk("perf_cnt_rst", {128'd0, bubble_cnt}, 160'd0);
`endif

        // Randomized traffic over a narrow register range to provoke dependencies.
        for (int n = 0; n < 600; n++) begin
            set_in(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 7) != 0), 3'($urandom), 3'($urandom), 2'($urandom),
                   $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
